// File: rtl/shift_seq.sv
// Load-then-shift sequencer driving a WIDTH-bit universal shift register (sel/i_par/lsb_in/msb_in).
// Optional macro SHIFT_SEQ_PAUSE_EN adds a pause input that stalls the SHIFT phase.
module shift_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_len,
    input  logic             ser_in,
`ifdef SHIFT_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] i_par,
    output logic             lsb_in,
    output logic             msb_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             stall;
    logic             shifting;

`ifdef SHIFT_SEQ_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = (in_len > LEN_MAX) ? LEN_MAX : in_len;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (!stall) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
        end
    end

    // Outputs are gated by rst so the datapath sees a clean hold while reset is held.
    assign shifting = !rst && (state_q == S_SHIFT) && !stall;
    assign in_ready = !rst && (state_q == S_IDLE);
    assign busy     = !rst && (state_q != S_IDLE);
    assign done     = !rst && (state_q == S_DONE);
    assign i_par    = (!rst && (state_q == S_LOAD)) ? data_q : '0;
    assign lsb_in   = shifting && !dir_q && ser_in;
    assign msb_in   = shifting && dir_q && ser_in;

    always_comb begin
        sel = 2'b00;
        if (!rst) begin
            if (state_q == S_LOAD) begin
                sel = 2'b11;
            end else if (shifting) begin
                sel = dir_q ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Randomised scoreboard bench for shift_seq: driver pushes expected command responses,
// a negedge monitor observes the sel/i_par/serial/done bus and checks them.
module tb_shift_seq;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic [CNT_W-1:0] in_len;
    logic             ser_in;
    logic [1:0]       sel;
    logic [WIDTH-1:0] i_par;
    logic             lsb_in;
    logic             msb_in;
    logic             busy;
    logic             done;
`ifdef SHIFT_SEQ_PAUSE_EN
    logic             pause = 1'b0;
`endif

    shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .in_len   (in_len),
        .ser_in   (ser_in),
`ifdef SHIFT_SEQ_PAUSE_EN
        .pause    (pause),
`endif
        .sel      (sel),
        .i_par    (i_par),
        .lsb_in   (lsb_in),
        .msb_in   (msb_in),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             dir;
        int               n;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial data is free-running random; the monitor checks it is routed on every shift.
    initial ser_in = 1'b0;
    always @(posedge clk) begin
        #1 ser_in = 1'($urandom_range(0, 1));
    end

    function automatic void check(string name, integer act, integer exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endfunction

    // Reference: the register shifts min(len, WIDTH) times.
    function automatic int ref_shifts(int len);
        return (len > WIDTH) ? WIDTH : len;
    endfunction

    // ---------------- monitor ----------------
    exp_t cur;
    bit   active   = 1'b0;
    int   load_cyc = 0;
    int   shifts   = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {in_ready, sel, i_par, lsb_in, msb_in, busy, done}, 0);
            active = 1'b0;
        end else begin
            check("ready_vs_busy", in_ready, !busy);
            check("done_sel", (done && sel != 2'b00), 0);
            if (sel == 2'b11) begin
                if (active || sb.size() == 0) begin
                    flag("load_unexpected");
                end else begin
                    cur = sb[0];
                    check("i_par", i_par, cur.data);
                    check("load_cycle", cyc, cur.acc + 1);
                    active   = 1'b1;
                    load_cyc = cyc;
                    shifts   = 0;
                end
            end else if (sel == 2'b01 || sel == 2'b10) begin
                if (!active) begin
                    flag("shift_unexpected");
                end else begin
                    check("shift_dir", sel, cur.dir ? 2 : 1);
                    check("ser_path", {lsb_in, msb_in}, cur.dir ? {1'b0, ser_in} : {ser_in, 1'b0});
                    shifts++;
                end
            end else begin
                check("hold_serial", {lsb_in, msb_in}, 0);
                if (done) begin
                    if (!active) begin
                        flag("done_unexpected");
                    end else begin
                        check("shift_count", shifts, cur.n);
                        check("done_cycle", cyc, load_cyc + 1 + cur.n);
                        void'(sb.pop_front());
                        active = 1'b0;
                    end
                end else if (active) begin
                    flag("stall_unexpected");
                end
            end
        end
    end

    // ---------------- driver ----------------
    int  prev_acc = 0;
    int  prev_n   = 0;
    bit  b2b      = 1'b0;

    task automatic issue(input logic [WIDTH-1:0] d, input logic dir, input int len);
        exp_t e;
        int   waited;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_len   = CNT_W'(len);
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 40) begin
                flag("accept_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        e.data = d;
        e.dir  = dir;
        e.n    = ref_shifts(len);
        e.acc  = cyc;
        sb.push_back(e);
        if (b2b) check("b2b_spacing", cyc - prev_acc, 3 + prev_n);
        prev_acc = cyc;
        prev_n   = e.n;
        b2b      = 1'b1;
        // Keep in_valid asserted and scramble the fields to prove only captured copies are used.
        @(posedge clk);
        #1;
        in_data = WIDTH'($urandom);
        in_dir  = 1'($urandom);
        in_len  = CNT_W'($urandom);
    endtask

    task automatic gap(input int k);
        in_valid = 1'b0;
        b2b      = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int waited;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        in_len   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_init", in_ready, 1);

        // Directed cases, back to back with in_valid held high.
        issue(4'b1010, 1'b0, 2);
        issue(4'b0110, 1'b1, 4);
        issue(4'b1111, 1'b0, 0);
        issue(4'b0001, 1'b1, 7);
        gap(2);
        wait_drain();

        // Reset in the middle of a SHIFT phase aborts the command.
        issue(4'b1001, 1'b0, 4);
        in_valid = 1'b0;
        waited   = 0;
        while (!(sel == 2'b01) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("reached_shift", sel, 2'b01);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        b2b = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        check("sel_after_rst", sel, 0);
        repeat (6) @(posedge clk);
        #1;

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            issue(WIDTH'($urandom), 1'($urandom), $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        end
        gap(1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
